// File: rtl/gemm_pkg.sv
// Shared types and default geometry for the GEMM result drain.
// Contents: drain_state_t (drain FSM states), OUT_DATA_WIDTH, WORD_DATA_WIDTH, LANES.
package gemm_pkg;

    localparam int OUT_DATA_WIDTH  = 32;
    localparam int WORD_DATA_WIDTH = 2048;
    localparam int LANES           = WORD_DATA_WIDTH / OUT_DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        STREAM,
        DONE
    } drain_state_t;

endpackage

// File: rtl/gemm_drain_lane_mux.sv
// Word buffer plus lane select for the GEMM result drain.
// Ports:
//   clk_i, rst_i   clock, async active-high reset (clears the buffers)
//   load_i         capture word_i into the active buffer
//   word_i         SRAM C read word
//   load_next_i    capture word_i into the prefetch buffer (GEMM_DRAIN_PREFETCH_EN only)
//   swap_i         move the prefetch buffer into the active buffer (GEMM_DRAIN_PREFETCH_EN only)
//   lane_i         lane to present
//   data_o         selected element of the active buffer
// Build option: GEMM_DRAIN_PREFETCH_EN adds the second (prefetch) word buffer.
module gemm_drain_lane_mux
    import gemm_pkg::*;
#(
    parameter int OutDataWidth  = OUT_DATA_WIDTH,
    parameter int WordDataWidth = WORD_DATA_WIDTH,
    parameter int Lanes         = WordDataWidth / OutDataWidth,
    parameter int LaneWidth     = $clog2(Lanes)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     load_i,
    input  logic [WordDataWidth-1:0] word_i,
`ifdef GEMM_DRAIN_PREFETCH_EN
    input  logic                     load_next_i,
    input  logic                     swap_i,
`endif
    input  logic [LaneWidth-1:0]     lane_i,
    output logic [OutDataWidth-1:0]  data_o
);

    logic [WordDataWidth-1:0] word_q;

`ifdef GEMM_DRAIN_PREFETCH_EN
    logic [WordDataWidth-1:0] next_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            next_q <= '0;
        end else begin
            if (load_i) begin
                word_q <= word_i;
            end else if (swap_i) begin
                word_q <= next_q;
            end
            if (load_next_i) begin
                next_q <= word_i;
            end
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
        end else if (load_i) begin
            word_q <= word_i;
        end
    end
`endif

    assign data_o = word_q[lane_i*OutDataWidth +: OutDataWidth];

endmodule

// File: rtl/gemm_result_drain.sv
// Drains an M x N block of GEMM results from SRAM C as a ready/valid element stream.
// Ports:
//   clk_i, rst_i                    clock, async active-high reset
//   start_i, M_size_i, N_size_i,    start a drain of M*N elements beginning at
//   base_addr_i                     word base_addr_i
//   sram_c_addr_o, sram_c_rdata_i   SRAM C read port (data one cycle after address)
//   res_data_o, res_valid_o,        element stream, lane 0 of each word first;
//   res_ready_i, res_last_o         res_last_o marks the final element
//   busy_o, done_o                  drain in progress / one-cycle completion pulse
// Build option: GEMM_DRAIN_PREFETCH_EN fetches the next word while the current one
// streams, removing the FETCH/LOAD bubble between words.
//
// State  | Meaning
// IDLE   | waiting for start_i
// FETCH  | present base+word_idx to SRAM C
// LOAD   | capture the read word into the buffer
// STREAM | emit lanes of the buffered word
// DONE   | one-cycle done_o pulse
module gemm_result_drain
    import gemm_pkg::*;
#(
    parameter int OutDataWidth  = OUT_DATA_WIDTH,
    parameter int WordDataWidth = WORD_DATA_WIDTH,
    parameter int AddrWidth     = 12,
    parameter int SizeAddrWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    input  logic [AddrWidth-1:0]     base_addr_i,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    input  logic [WordDataWidth-1:0] sram_c_rdata_i,
    output logic [OutDataWidth-1:0]  res_data_o,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic                     res_last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int Lanes     = WordDataWidth / OutDataWidth;
    localparam int LaneWidth = $clog2(Lanes);

    drain_state_t             state_q, state_d;
    logic [SizeAddrWidth-1:0] total_q, elem_q, total_d;
    logic [AddrWidth-1:0]     base_q, word_idx_q, addr_q, fetch_addr;
    logic [LaneWidth-1:0]     lane_q;
    logic                     hs, is_last, lane_end, load_word, word_adv;

    assign total_d    = M_size_i * N_size_i;
    assign fetch_addr = base_q + word_idx_q;
    assign hs         = (state_q == STREAM) && res_ready_i;
    assign is_last    = (elem_q == total_q - 1'b1);
    assign lane_end   = (lane_q == LaneWidth'(Lanes - 1));
    assign res_last_o = (state_q == STREAM) && is_last;
    assign busy_o     = (state_q != IDLE);

`ifdef GEMM_DRAIN_PREFETCH_EN
    logic                 pf_pend_q, pf_vld_q, pf_issue, has_next, swap_word;
    logic [AddrWidth-1:0] pf_addr;

    // Another word follows the one now streaming.
    assign has_next = (elem_q - SizeAddrWidth'(lane_q) + SizeAddrWidth'(Lanes)) < total_q;
    assign pf_issue = (state_q == STREAM) && has_next && !pf_vld_q && !pf_pend_q;
    assign pf_addr  = fetch_addr + 1'b1;
    assign sram_c_addr_o = (state_q == FETCH) ? fetch_addr :
                           pf_issue           ? pf_addr    : addr_q;
`else
    assign sram_c_addr_o = (state_q == FETCH) ? fetch_addr : addr_q;
`endif

    always_comb begin
        state_d     = state_q;
        res_valid_o = 1'b0;
        done_o      = 1'b0;
        load_word   = 1'b0;
        word_adv    = 1'b0;
`ifdef GEMM_DRAIN_PREFETCH_EN
        swap_word   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (total_d == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                load_word = 1'b1;
                state_d   = STREAM;
            end
            STREAM: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else if (lane_end) begin
                        word_adv = 1'b1;
`ifdef GEMM_DRAIN_PREFETCH_EN
                        if (pf_vld_q) begin
                            swap_word = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
`else
                        state_d = FETCH;
`endif
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            total_q    <= '0;
            elem_q     <= '0;
            base_q     <= '0;
            word_idx_q <= '0;
            addr_q     <= '0;
            lane_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= sram_c_addr_o;
            if (state_q == IDLE && start_i) begin
                total_q    <= total_d;
                base_q     <= base_addr_i;
                word_idx_q <= '0;
                elem_q     <= '0;
            end
            if (load_word) begin
                lane_q <= '0;
            end else if (hs) begin
                // Lane count is a power of two, so lane 63 rolls over to 0.
                lane_q <= lane_q + 1'b1;
            end
            if (hs) begin
                elem_q <= elem_q + 1'b1;
            end
            if (word_adv) begin
                word_idx_q <= word_idx_q + 1'b1;
            end
        end
    end

`ifdef GEMM_DRAIN_PREFETCH_EN
    // A prefetch landing after the stream has left STREAM is dropped; FETCH
    // re-reads that word through the normal path.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pf_pend_q <= 1'b0;
            pf_vld_q  <= 1'b0;
        end else begin
            pf_pend_q <= pf_issue;
            if (swap_word || state_q != STREAM) begin
                pf_vld_q <= 1'b0;
            end else if (pf_pend_q) begin
                pf_vld_q <= 1'b1;
            end
        end
    end
`endif

    gemm_drain_lane_mux #(
        .OutDataWidth  (OutDataWidth),
        .WordDataWidth (WordDataWidth)
    ) u_lane_mux (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (load_word),
        .word_i      (sram_c_rdata_i),
`ifdef GEMM_DRAIN_PREFETCH_EN
        .load_next_i (pf_pend_q && state_q == STREAM),
        .swap_i      (swap_word),
`endif
        .lane_i      (lane_q),
        .data_o      (res_data_o)
    );

endmodule

// File: tb/tb_gemm_result_drain.sv
module tb_gemm_result_drain;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   m_size, n_size;
    logic [11:0]   base_addr, sram_addr;
    logic [2047:0] sram_rdata;
    logic [31:0]   res_data;
    logic          res_valid, res_ready, res_last, busy, done;

    always #5 clk = ~clk;

    gemm_result_drain dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .M_size_i       (m_size),
        .N_size_i       (n_size),
        .base_addr_i    (base_addr),
        .sram_c_addr_o  (sram_addr),
        .sram_c_rdata_i (sram_rdata),
        .res_data_o     (res_data),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_last_o     (res_last),
        .busy_o         (busy),
        .done_o         (done)
    );

    // Element content encodes its SRAM address and lane.
    function automatic logic [31:0] ev(input logic [11:0] a, input logic [5:0] l);
        logic [7:0] s;
        s = a[7:0] * 8'd7 + {2'b00, l};
        return {4'hC, a, 2'b10, l, s};
    endfunction

    function automatic logic [2047:0] mk_word(input logic [11:0] a);
        logic [2047:0] w;
        for (int l = 0; l < 64; l++) w[l*32 +: 32] = ev(a, 6'(l));
        return w;
    endfunction

    // SRAM C: data one cycle after address.
    always @(posedge clk) sram_rdata <= mk_word(sram_addr);

    int errors = 0, checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    function void chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endfunction

    // Model state
    int          tot = 0, exp_idx = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
    int          gap = 0, streak = 0, max_streak = 0, stall_cnt = 0;
    logic [11:0] mbase = '0;
    bit          active = 0, prev_stalled = 0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [31:0] cap [0:255];

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (active && !rst) begin
            if (done_cnt == 0 || done) chk(busy == 1'b1, "busy_during_drain", busy, 1);
            if (done) chk(exp_idx == tot, "done_after_last", exp_idx, tot);
            if (res_valid) begin
                if (exp_idx >= tot) begin
                    chk(1'b0, "extra_element", exp_idx, tot);
                end else begin
                    logic [31:0] want;
                    want = ev(12'(int'(mbase) + exp_idx / 64), 6'(exp_idx % 64));
                    chk(res_data == want, "elem_data", res_data, want);
                    chk(res_last == (exp_idx == tot - 1), "elem_last", res_last, exp_idx == tot - 1);
                    if (exp_idx < 256) cap[exp_idx] = res_data;
                end
                if (prev_stalled) begin
                    chk(res_data == prev_data, "stall_data_stable", res_data, prev_data);
                    chk(res_last == prev_last, "stall_last_stable", res_last, prev_last);
                end
                prev_stalled = !res_ready;
                prev_data    = res_data;
                prev_last    = res_last;
                if (res_ready) begin
                    exp_idx++;
                    streak++;
                    if (streak > max_streak) max_streak = streak;
                end else begin
                    streak = 0;
                end
            end else begin
                prev_stalled = 0;
                streak = 0;
                if (exp_idx > 0 && exp_idx < tot) gap++;
            end
        end
    end

    task automatic run(input int m, input int n, input int b, input int stall_at, input int abort_at);
        bit finished;
        tot = m * n;
        mbase = 12'(b);
        exp_idx = 0; done_cnt = 0; gap = 0; streak = 0; max_streak = 0; stall_cnt = 0;
        prev_stalled = 0;
        @(posedge clk); #1;
        m_size = 32'(m); n_size = 32'(n); base_addr = 12'(b); start = 1'b1; res_ready = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        active = 1;
        finished = 0;
        for (int k = 0; k < 3000; k++) begin
            if (done_cnt > 0) begin
                finished = 1;
                break;
            end
            if (abort_at >= 0 && exp_idx == abort_at) begin
                rst = 1'b1;
                #1;
                active = 0;
                chk(res_valid == 1'b0, "abort_valid", res_valid, 0);
                chk(busy == 1'b0, "abort_busy", busy, 0);
                chk(res_last == 1'b0, "abort_last", res_last, 0);
                chk(sram_addr == 12'd0, "abort_addr", sram_addr, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                chk(done_cnt == 0, "abort_no_done", done_cnt, 0);
                chk(busy == 1'b0, "abort_idle", busy, 0);
                return;
            end
            res_ready = !(exp_idx == stall_at && stall_cnt < 5);
            if (!res_ready) stall_cnt++;
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        chk(finished, "drain_timeout", finished, 1);
        repeat (2) @(posedge clk);
        #1;
        active = 0;
        chk(exp_idx == tot, "elem_count", exp_idx, tot);
        chk(done_cnt == 1, "done_pulses", done_cnt, 1);
        chk(busy == 1'b0, "idle_after", busy, 0);
    endtask

    initial begin
        logic [11:0] addr_before;
        rst = 1'b1; start = 1'b0; res_ready = 1'b1;
        m_size = '0; n_size = '0; base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(res_valid == 1'b0, "rst_valid", res_valid, 0);
        chk(res_last == 1'b0, "rst_last", res_last, 0);
        chk(done == 1'b0, "rst_done", done, 0);
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(sram_addr == 12'd0, "rst_addr", sram_addr, 0);
        chk(res_data == 32'd0, "rst_data", res_data, 0);
        rst = 1'b0;

        // One full word at base 1
        run(16, 4, 1, -1, -1);
        chk(cap[0] == 32'hC001_8007, "w1_lane0", cap[0], 32'hC001_8007);
        chk(cap[63] == 32'hC001_BF46, "w1_lane63", cap[63], 32'hC001_BF46);
        chk(max_streak == 64, "w1_streak", max_streak, 64);

        // Partial final word: 68 elements
        run(4, 17, 10, -1, -1);
        chk(cap[64] == 32'hC00B_804D, "p2_lane0", cap[64], 32'hC00B_804D);
        chk(cap[67] == 32'hC00B_8350, "p2_lane3_last", cap[67], 32'hC00B_8350);

        // Backpressure on lane 10
        run(16, 4, 1, 10, -1);
        chk(cap[10] == 32'hC001_8A11, "stall_lane10", cap[10], 32'hC001_8A11);

        // Empty drain
        addr_before = sram_addr;
        run(0, 8, 7, -1, -1);
        chk(done_cyc - start_cyc == 1, "empty_done_latency", done_cyc - start_cyc, 1);
        chk(sram_addr == addr_before, "empty_no_fetch", sram_addr, addr_before);

        // Address wrap, two full words
        run(16, 8, 4095, -1, -1);
        chk(cap[0] == 32'hCFFF_80F9, "wrap_lane0", cap[0], 32'hCFFF_80F9);
        chk(cap[64] == 32'hC000_8000, "wrap_second_word", cap[64], 32'hC000_8000);
`ifdef GEMM_DRAIN_PREFETCH_EN
        chk(max_streak == 128, "wrap_streak", max_streak, 128);
        chk(gap == 0, "word_gap", gap, 0);
`else
        chk(max_streak == 64, "wrap_streak", max_streak, 64);
        chk(gap == 2, "word_gap", gap, 2);
`endif

        // Reset mid-drain, then a clean restart
        run(16, 4, 1, -1, 20);
        run(16, 4, 1, -1, -1);
        chk(cap[63] == 32'hC001_BF46, "restart_lane63", cap[63], 32'hC001_BF46);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gemm_result_drain.md
GEMM_RESULT_DRAIN -- requirements
Module: gemm_result_drain

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning): OutDataWidth, 32, width of one C element.
REQ-002 The block SHALL expose parameter WordDataWidth, 2048, width of one SRAM C word (Lanes = WordDataWidth/OutDataWidth = 64).
REQ-003 The block SHALL expose parameters AddrWidth, 12, SRAM C address width; and SizeAddrWidth, 32, width of the size inputs.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports (name, direction, width, meaning): clk_i, in, 1, clock; rst_i, in, 1, async active-high reset.
REQ-005 The block SHALL have control ports: start_i, in, 1, start drain; M_size_i, in, SizeAddrWidth, rows; N_size_i, in, SizeAddrWidth, columns; base_addr_i, in, AddrWidth, first C word.
REQ-006 The block SHALL have SRAM ports: sram_c_addr_o, out, AddrWidth, read address; sram_c_rdata_i, in, WordDataWidth, read data valid one cycle after address.
REQ-007 The block SHALL have stream ports: res_data_o, out, OutDataWidth, element; res_valid_o, out, 1; res_ready_i, in, 1; res_last_o, out, 1, final element.
REQ-008 The block SHALL have status ports: busy_o, out, 1, drain in progress; done_o, out, 1, one-cycle completion pulse.

Function
REQ-009 The FSM SHALL have states IDLE, FETCH, LOAD, STREAM and DONE.
REQ-010 In IDLE with start_i=1, the block SHALL latch Total=M_size_i*N_size_i (SizeAddrWidth bits, truncating) and base_addr_i, and go to FETCH, or to DONE if Total=0.
REQ-011 FETCH SHALL drive sram_c_addr_o=base+word_idx for one cycle and then go to LOAD.
REQ-012 LOAD SHALL capture sram_c_rdata_i into the word buffer at the end of the cycle and go to STREAM.
REQ-013 STREAM SHALL emit lanes in order from lane 0 (bits [31:0]) upward, with res_valid_o=1.
REQ-014 A lane SHALL advance only on res_valid_o&&res_ready_i; while stalled, res_data_o and res_last_o SHALL stay stable.
REQ-015 After lane 63 of a non-final word is handshaken, the FSM SHALL return to FETCH and word_idx SHALL increment.
REQ-016 The final word SHALL emit only Total-64*(Words-1) lanes, where Words=ceil(Total/64).
REQ-017 res_last_o SHALL be 1 only with element Total-1; its handshake SHALL move the FSM to DONE.
REQ-018 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-019 busy_o SHALL be 1 in every state except IDLE.
REQ-020 start_i SHALL be ignored when not in IDLE.
REQ-021 base+word_idx SHALL wrap modulo 2^AddrWidth.
REQ-022 Element data SHALL pass bit-exact, with no sign handling.
REQ-023 Outside FETCH, sram_c_addr_o SHALL hold its last value.

Reset
REQ-024 On rst_i=1 the block SHALL immediately enter IDLE with res_valid_o=0, res_last_o=0, done_o=0, busy_o=0, sram_c_addr_o=0, counters=0 and buffer=0.
REQ-025 Reset mid-drain SHALL abandon the transfer, with no done_o pulse.

Configuration
REQ-026 With GEMM_DRAIN_PREFETCH_EN defined, the block SHALL add a second word buffer and issue the next FETCH while the current word streams, so the first lane of the next word follows the last lane of the previous word with no bubble when res_ready_i=1.
REQ-027 Without GEMM_DRAIN_PREFETCH_EN, the block SHALL insert a 2-cycle bubble (FETCH, LOAD) between words.

Structure
REQ-028 gemm_pkg SHALL hold drain_state_t and the OutDataWidth/WordDataWidth/Lanes constants.
REQ-029 One sub-module, gemm_drain_lane_mux (word buffer plus lane select), SHALL be used.

Verification
REQ-030 M=16, N=4, base=1, res_ready_i=1: 64 elements SHALL match word 1 lanes 0..63, res_last_o SHALL be on the 64th, and done_o SHALL pulse once.
REQ-031 M=4, N=17: 2 words SHALL be read and 68 elements emitted, with res_last_o on lane 3 of the second word.
REQ-032 res_ready_i held low 5 cycles during lane 10: res_data_o SHALL be stable for the stall and no element SHALL be lost or duplicated.
REQ-033 M=0, N=8: done_o SHALL pulse 1 cycle after start, with no FETCH and no res_valid_o.
REQ-034 base=4095, M=16, N=8: the second word address SHALL be 0 (wrap).
REQ-035 rst_i during lane 20, then restart with M=16, N=4: the block SHALL be idle immediately and then complete a clean 64-element drain; with the macro, M=16, N=8 SHALL show 128 consecutive handshakes.
